// File: rtl/seg_scan_driver.sv
// Multiplexed 8-digit seven-segment scan driver with a per-slot prescaler.
// Optional anti-ghosting dead time is enabled by defining SEG_GHOST_BLANK_EN.
module seg_scan_driver #(
    parameter int unsigned PRESCALE = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] one_digit,
    input  logic       blank_all,
    output logic [2:0] refreshcounter,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

    logic [PsW-1:0] prescaler_q;
    logic [2:0]     refresh_q;
    logic           load_q;
    logic [7:0]     an_q;
    logic [6:0]     seg_q;
    logic           tick;
    logic [7:0]     anode_sel;

`ifdef SEG_GHOST_BLANK_EN
    localparam logic [PsW-1:0] PsPreTick = PsW'(PRESCALE - 2);
    logic [4:0] dead_q;
    logic       pre_tick;
    assign pre_tick = (prescaler_q == PsPreTick);
`endif

    assign tick      = (prescaler_q == PsLast);
    assign anode_sel = ~(8'd1 << refresh_q);

    // Cathode pattern {g,f,e,d,c,b,a}, active low.
    function automatic logic [6:0] decode(input logic [7:0] code);
        logic [6:0] pat;
        case (code)
            8'h00:   pat = 7'b1000000;
            8'h01:   pat = 7'b1111001;
            8'h02:   pat = 7'b0100100;
            8'h03:   pat = 7'b0110000;
            8'h04:   pat = 7'b0011001;
            8'h05:   pat = 7'b0010010;
            8'h06:   pat = 7'b0000010;
            8'h07:   pat = 7'b1111000;
            8'h08:   pat = 7'b0000000;
            8'h09:   pat = 7'b0010000;
            8'h0A:   pat = 7'b0010010;
            8'h0B:   pat = 7'b0101111;
            8'h0C:   pat = 7'b1000110;
            8'h0E:   pat = 7'b0000110;
            8'hFE:   pat = 7'b0111111;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prescaler_q <= '0;
            refresh_q   <= 3'd0;
            load_q      <= 1'b0;
            an_q        <= 8'hFF;
            seg_q       <= 7'b1111111;
`ifdef SEG_GHOST_BLANK_EN
            dead_q      <= 5'd0;
`endif
        end else begin
            prescaler_q <= tick ? '0 : prescaler_q + PsW'(1);
            load_q      <= tick;
            if (tick) begin
                refresh_q <= refresh_q + 3'd1;
            end
`ifdef SEG_GHOST_BLANK_EN
            // Go dark one edge early so the tick cycle is already blank.
            if (pre_tick) begin
                an_q <= 8'hFF;
            end
            if (dead_q != 5'd0) begin
                dead_q <= dead_q - 5'd1;
                if (dead_q == 5'd1) begin
                    an_q <= anode_sel;
                end
            end
            if (load_q) begin
                seg_q  <= decode(one_digit);
                dead_q <= 5'd15;
            end
`else
            if (load_q) begin
                seg_q <= decode(one_digit);
                an_q  <= anode_sel;
            end
`endif
        end
    end

    assign refreshcounter = refresh_q;
    assign an             = blank_all ? 8'hFF : an_q;
    assign seg            = seg_q;
    assign dp             = 1'b1;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (PRESCALE=4, or 40 with dead time).
module tb_seg_scan_driver;

`ifdef SEG_GHOST_BLANK_EN
    localparam int unsigned P = 40;
`else
    localparam int unsigned P = 4;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] one_digit;
    logic       blank_all = 1'b0;
    logic [2:0] refreshcounter;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    logic [7:0] code_tbl [8];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Digit-select model: code for the currently selected slot.
    always_comb one_digit = code_tbl[refreshcounter];

    seg_scan_driver #(.PRESCALE(P)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .one_digit      (one_digit),
        .blank_all      (blank_all),
        .refreshcounter (refreshcounter),
        .an             (an),
        .seg            (seg),
        .dp             (dp)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [7:0] c);
        for (int i = 0; i < 8; i++) code_tbl[i] = c;
    endtask

    // Hand-written reference patterns for codes 0x00..0x0F.
    logic [6:0] ref_lo [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0010010, 7'b0101111,
        7'b1000110, 7'b1111111, 7'b0000110, 7'b1111111
    };

    function automatic logic [6:0] ref_seg(input int c);
        if (c < 16) return ref_lo[c];
        if (c == 8'hFE) return 7'b0111111;
        return 7'b1111111;
    endfunction

    initial begin
        for (int i = 0; i < 8; i++) code_tbl[i] = 8'(i);
        code_tbl[1] = 8'h03;
        reset_n = 1'b0;
        step(3);
        check("reset_an", an, 8'hFF);
        check("reset_seg", {1'b0, seg}, 8'h7F);
        check("reset_rc", {5'd0, refreshcounter}, 8'd0);
        check("reset_dp", {7'd0, dp}, 8'd1);
        reset_n = 1'b1;

`ifdef SEG_GHOST_BLANK_EN
        step(41);  // cycle 41: seg loaded, anode still dark
        check("gh_seg1", {1'b0, seg}, 8'h30);
        check("gh_an41", an, 8'hFF);
        step(14);  // cycle 55
        check("gh_an55", an, 8'hFF);
        step(1);   // cycle 56
        check("gh_an56", an, 8'hFD);
        step(22);  // cycle 78
        check("gh_an78", an, 8'hFD);
        step(1);   // cycle 79 tick
        check("gh_an79", an, 8'hFF);
        step(1);   // cycle 80 load
        check("gh_an80", an, 8'hFF);
        check("gh_rc80", {5'd0, refreshcounter}, 8'd2);
        step(1);
        check("gh_seg2", {1'b0, seg}, 8'h24);
        check("gh_an81", an, 8'hFF);
        step(14);  // cycle 95
        check("gh_an95", an, 8'hFF);
        step(1);   // cycle 96
        check("gh_an96", an, 8'hFB);
        check("gh_dp", {7'd0, dp}, 8'd1);
        blank_all = 1'b1;
        #1;
        check("gh_blank", an, 8'hFF);
        blank_all = 1'b0;
        #1;
        check("gh_unblank", an, 8'hFB);
`else
        step(3);   // cycle 3: tick
        check("basic_rc3", {5'd0, refreshcounter}, 8'd0);
        step(1);   // cycle 4: load
        check("basic_rc4", {5'd0, refreshcounter}, 8'd1);
        check("basic_an4", an, 8'hFF);
        step(1);   // cycle 5
        check("basic_an5", an, 8'hFD);
        check("basic_seg5", {1'b0, seg}, 8'h30);

        code_tbl[1] = 8'h01;
        for (int m = 1; m <= 8; m++) begin
            int rc;
            step(4);
            rc = (1 + m) % 8;
            check("wrap_rc", {5'd0, refreshcounter}, 8'(rc));
            check("wrap_an", an, ~(8'd1 << rc));
            check("wrap_seg", {1'b0, seg}, {1'b0, ref_seg(rc)});
        end

        // rc = 1, prescaler = 1 here
        blank_all = 1'b1;
        #1;
        check("blank_an", an, 8'hFF);
        step(4);
        check("blank_rc", {5'd0, refreshcounter}, 8'd2);
        check("blank_an2", an, 8'hFF);
        blank_all = 1'b0;
        #1;
        check("unblank_an", an, 8'hFB);

        for (int c = 0; c < 256; c++) begin
            set_all(8'(c));
            step(4);
            check("code_seg", {1'b0, seg}, {1'b0, ref_seg(c)});
        end

        set_all(8'h08);
        step(4);
        check("pre_rst_seg", {1'b0, seg}, 8'h00);
        set_all(8'h01);
        step(3);   // load cycle
        reset_n = 1'b0;
        step(1);
        check("rst_load_an", an, 8'hFF);
        check("rst_load_seg", {1'b0, seg}, 8'h7F);
        check("rst_load_rc", {5'd0, refreshcounter}, 8'd0);
        reset_n = 1'b1;
        set_all(8'h08);
        step(4);
        check("rel_rc", {5'd0, refreshcounter}, 8'd1);
        check("rel_an", an, 8'hFF);
        step(1);
        check("rel_an2", an, 8'hFD);
        check("rel_seg", {1'b0, seg}, 8'h00);
        check("dp_end", {7'd0, dp}, 8'd1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
